aq_gemac_arp_seq: RTL and testbench
===================================

// Module: aq_gemac_arp_seq
// PURPOSE
//  ARP-resolution sequencer between aq_gemac_ipctrl's ARP cache port (ARPC_*) and aq_gemac_udp_loop.
//  Requests resolution of the peer IP and retries on timeout, with a failure limit.
//  Latches the resolved peer MAC and drives the peer-enable/peer-MAC inputs of the UDP client.
//  Optionally re-resolves periodically while bound.
// PARAMETERS
//  RETRY_CYCLES    32'd100_000_000  cycles allowed per request attempt (REQ+WAIT) before retry (1 s @100 MHz)
//  MAX_RETRY       4'd8             attempts before FAIL; legal range 1..15
//  REFRESH_CYCLES  32'd0            cycles in BOUND before re-request; 0 = refresh disabled
// PORTS
//  CLK          in   1   system clock (SYS_CLK domain of ipctrl)
//  RST          in   1   reset, asynchronous, active-high
//  ENABLE       in   1   1 = run sequencer; 0 = return to IDLE
//  ARPC_VALID   in   1   ipctrl: cache holds valid entry for peer IP
//  ARPC_ENABLE  in   1   ipctrl: request accepted (level or pulse)
//  PEER_MAC_IN  in   48  ipctrl PEER_MAC_ADDRESS
//  ARPC_REQUEST out  1   request to ipctrl ARP cache
//  PEER_ENABLE  out  1   peer bound; to udp_loop UDP_PEER_ENABLE
//  PEER_MAC     out  48  latched peer MAC; to udp_loop UDP_PEER_MAC_ADDRESS
//  ARP_FAIL     out  1   sticky failure flag
//  RETRY_COUNT  out  4   timeouts in current resolution
//  STATE        out  3   FSM state code, for debug/ILA
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timer=0; retry=0.
//  All outputs are registered. State codes: IDLE=0, CHECK=1, REQ=2, WAIT=3, BOUND=4, FAIL=5.
//  Global rule: ENABLE=0 in any state -> IDLE on the next edge; PEER_ENABLE, PEER_MAC, ARP_FAIL, RETRY_COUNT, ARPC_REQUEST cleared.
//  IDLE:  ENABLE=1 -> CHECK.
//  CHECK (one cycle):
//   - ARPC_VALID=1 -> BOUND; latch PEER_MAC<=PEER_MAC_IN.
//   - Otherwise -> REQ; timer<=0.
//  REQ:   ARPC_REQUEST=1.
//   - ARPC_ENABLE=1 -> WAIT; ARPC_REQUEST drops the same edge.
//  WAIT:  ARPC_VALID=1 -> BOUND; latch PEER_MAC.
//  Timer (REQ and WAIT): increments every cycle.
//   - On timer==RETRY_CYCLES-1 without ARPC_VALID: if RETRY_COUNT+1==MAX_RETRY -> FAIL,
//     else RETRY_COUNT++, timer<=0 -> REQ.
//   - ARPC_VALID and timeout on the same cycle: BOUND wins, no increment.
//  BOUND: PEER_ENABLE=1; RETRY_COUNT<=0 on entry.
//   - ARPC_VALID falls -> CHECK; PEER_ENABLE<=0 (cache invalidated).
//   - REFRESH_CYCLES!=0 and refresh timer==REFRESH_CYCLES-1 -> REQ; timer<=0.
//     PEER_ENABLE and PEER_MAC are held through the refresh REQ/WAIT; PEER_MAC is updated only on the next BOUND entry.
//   - Refresh failure -> FAIL clears PEER_ENABLE.
//  FAIL: ARP_FAIL=1, ARPC_REQUEST=0, PEER_ENABLE=0; held until ENABLE=0.
//  Latency: ENABLE rises at edge0 with ARPC_VALID=1 -> CHECK after edge1 -> PEER_ENABLE=1 after edge2.
//  Timers are 32-bit unsigned with no wrap: a timer clears on every state entry that uses it.
//  RETRY_COUNT never exceeds MAX_RETRY-1.
//  Reset asserted mid-request: ARPC_REQUEST drops asynchronously; no partial latch of PEER_MAC.
// TESTING (bench params RETRY_CYCLES=16, MAX_RETRY=3, REFRESH_CYCLES=64)
//  1 Cache hit: ARPC_VALID=1, PEER_MAC_IN=48'h0A0B0C0D0E0F, ENABLE 0->1
//    -> PEER_ENABLE=1 two edges later; PEER_MAC=48'h0A0B0C0D0E0F; ARPC_REQUEST never asserted.
//  2 Miss then resolve: ARPC_VALID=0; ARPC_ENABLE pulsed 3 cycles into REQ; ARPC_VALID=1 5 cycles later
//    -> ARPC_REQUEST high exactly 3 cycles; BOUND; RETRY_COUNT=0.
//  3 No response
//    -> ARPC_REQUEST re-asserts at 16-cycle intervals; RETRY_COUNT steps 0,1,2;
//       ARP_FAIL=1 after 48 cycles in REQ/WAIT; ENABLE=0 clears ARP_FAIL next edge.
//  4 Race: ARPC_VALID rises on the cycle timer==15
//    -> BOUND; RETRY_COUNT unchanged; no new request.
//  5 Refresh: bound with MAC A; after 64 cycles ARPC_REQUEST=1 while PEER_ENABLE stays 1; resolve with PEER_MAC_IN=B
//    -> PEER_MAC=B; PEER_ENABLE never dropped.
//  6 RST pulsed during REQ
//    -> ARPC_REQUEST=0 immediately; STATE=0; PEER_MAC=0; restart via ENABLE works.

Source files
------------

// File: rtl/aq_gemac_arp_seq_if.sv
// ----------------------------------------------------------------------------
// aq_gemac_arp_seq_if
//  Signal bundle between the ARP-resolution sequencer and its surroundings
//  (ipctrl ARP cache port on one side, udp_loop peer inputs on the other).
//
//  Signals
//   ENABLE        1   run sequencer; 0 returns it to IDLE
//   ARPC_VALID    1   ipctrl cache holds a valid entry for the peer IP
//   ARPC_ENABLE   1   ipctrl accepted the request (level or pulse)
//   PEER_MAC_IN   48  ipctrl PEER_MAC_ADDRESS
//   ARPC_REQUEST  1   request to the ipctrl ARP cache
//   PEER_ENABLE   1   peer bound; to udp_loop UDP_PEER_ENABLE
//   PEER_MAC      48  latched peer MAC; to udp_loop UDP_PEER_MAC_ADDRESS
//   ARP_FAIL      1   sticky failure flag
//   RETRY_COUNT   4   timeouts in the current resolution
//   STATE         3   sequencer state code for debug/ILA
//
//  Modports
//   master  side that controls the sequencer and consumes its results
//   slave   the sequencer itself
// ----------------------------------------------------------------------------
interface aq_gemac_arp_seq_if;
    logic        ENABLE;
    logic        ARPC_VALID;
    logic        ARPC_ENABLE;
    logic [47:0] PEER_MAC_IN;
    logic        ARPC_REQUEST;
    logic        PEER_ENABLE;
    logic [47:0] PEER_MAC;
    logic        ARP_FAIL;
    logic [3:0]  RETRY_COUNT;
    logic [2:0]  STATE;

    modport master (
        output ENABLE,
        output ARPC_VALID,
        output ARPC_ENABLE,
        output PEER_MAC_IN,
        input  ARPC_REQUEST,
        input  PEER_ENABLE,
        input  PEER_MAC,
        input  ARP_FAIL,
        input  RETRY_COUNT,
        input  STATE
    );

    modport slave (
        input  ENABLE,
        input  ARPC_VALID,
        input  ARPC_ENABLE,
        input  PEER_MAC_IN,
        output ARPC_REQUEST,
        output PEER_ENABLE,
        output PEER_MAC,
        output ARP_FAIL,
        output RETRY_COUNT,
        output STATE
    );
endinterface

// File: rtl/aq_gemac_arp_seq.sv
// ----------------------------------------------------------------------------
// aq_gemac_arp_seq
//  ARP-resolution sequencer between the ipctrl ARP cache port and udp_loop.
//  Requests resolution of the peer IP, retries on timeout up to MAX_RETRY
//  attempts, latches the resolved peer MAC and drives the UDP client's
//  peer-enable / peer-MAC inputs. Optionally re-resolves periodically while
//  bound (REFRESH_CYCLES != 0).
//
//  Parameters
//   RETRY_CYCLES    cycles allowed per attempt (REQ+WAIT) before a retry
//   MAX_RETRY       attempts before FAIL, 1..15
//   REFRESH_CYCLES  cycles in BOUND before re-request; 0 disables refresh
//
//  Ports
//   CLK   system clock
//   RST   asynchronous active-high reset
//   bus   aq_gemac_arp_seq_if.slave (ENABLE, ARPC_*, PEER_*, ARP_FAIL,
//         RETRY_COUNT, STATE); all outputs come straight from flops
//
//  State codes: IDLE=0, CHECK=1, REQ=2, WAIT=3, BOUND=4, FAIL=5.
// ----------------------------------------------------------------------------
module aq_gemac_arp_seq #(
    parameter logic [31:0] RETRY_CYCLES   = 32'd100_000_000,
    parameter logic [3:0]  MAX_RETRY      = 4'd8,
    parameter logic [31:0] REFRESH_CYCLES = 32'd0
) (
    input logic               CLK,
    input logic               RST,
    aq_gemac_arp_seq_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCheck = 3'd1,
        StReq   = 3'd2,
        StWait  = 3'd3,
        StBound = 3'd4,
        StFail  = 3'd5
    } state_e;

    localparam logic [31:0] RetryLast   = RETRY_CYCLES - 32'd1;
    localparam logic [31:0] RefreshLast = REFRESH_CYCLES - 32'd1;
    localparam logic        RefreshOn   = (REFRESH_CYCLES != 32'd0);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic        req_q, req_d;
    logic        peer_en_q, peer_en_d;
    logic [47:0] peer_mac_q, peer_mac_d;
    logic        fail_q, fail_d;

    logic [31:0] timer_inc;
    logic [3:0]  retry_inc;
    logic        timeout;
    logic        refresh_due;

    // Saturating count: the timer is cleared on every entry that uses it,
    // but BOUND with refresh disabled would otherwise wrap after 2^32 cycles.
    assign timer_inc   = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
    assign retry_inc   = retry_q + 4'd1;
    assign timeout     = (timer_q == RetryLast);
    assign refresh_due = RefreshOn && (timer_q == RefreshLast);

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        req_d      = req_q;
        peer_en_d  = peer_en_q;
        peer_mac_d = peer_mac_q;
        fail_d     = fail_q;

        if (!bus.ENABLE) begin
            state_d    = StIdle;
            timer_d    = 32'd0;
            retry_d    = 4'd0;
            req_d      = 1'b0;
            peer_en_d  = 1'b0;
            peer_mac_d = 48'd0;
            fail_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StCheck;
                end

                StCheck: begin
                    if (bus.ARPC_VALID) begin
                        state_d    = StBound;
                        peer_mac_d = bus.PEER_MAC_IN;
                        peer_en_d  = 1'b1;
                        retry_d    = 4'd0;
                        timer_d    = 32'd0;
                    end else begin
                        state_d = StReq;
                        timer_d = 32'd0;
                        req_d   = 1'b1;
                    end
                end

                StReq, StWait: begin
                    // A valid cache entry beats a coincident timeout.
                    if (bus.ARPC_VALID) begin
                        state_d    = StBound;
                        peer_mac_d = bus.PEER_MAC_IN;
                        peer_en_d  = 1'b1;
                        retry_d    = 4'd0;
                        timer_d    = 32'd0;
                        req_d      = 1'b0;
                    end else if (timeout) begin
                        if (retry_inc == MAX_RETRY) begin
                            state_d   = StFail;
                            req_d     = 1'b0;
                            peer_en_d = 1'b0;
                            fail_d    = 1'b1;
                        end else begin
                            state_d = StReq;
                            retry_d = retry_inc;
                            timer_d = 32'd0;
                            req_d   = 1'b1;
                        end
                    end else begin
                        timer_d = timer_inc;
                        if ((state_q == StReq) && bus.ARPC_ENABLE) begin
                            state_d = StWait;
                            req_d   = 1'b0;
                        end
                    end
                end

                StBound: begin
                    if (!bus.ARPC_VALID) begin
                        // Cache entry invalidated: stop the client, re-check.
                        state_d   = StCheck;
                        peer_en_d = 1'b0;
                        timer_d   = 32'd0;
                    end else if (refresh_due) begin
                        // Refresh keeps the current binding live; PEER_MAC
                        // is only replaced on the next BOUND entry.
                        state_d = StReq;
                        timer_d = 32'd0;
                        req_d   = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end

                StFail: begin
                    // Sticky until ENABLE drops.
                    state_d = StFail;
                end

                default: begin
                    state_d    = StIdle;
                    timer_d    = 32'd0;
                    retry_d    = 4'd0;
                    req_d      = 1'b0;
                    peer_en_d  = 1'b0;
                    peer_mac_d = 48'd0;
                    fail_d     = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            timer_q    <= 32'd0;
            retry_q    <= 4'd0;
            req_q      <= 1'b0;
            peer_en_q  <= 1'b0;
            peer_mac_q <= 48'd0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            req_q      <= req_d;
            peer_en_q  <= peer_en_d;
            peer_mac_q <= peer_mac_d;
            fail_q     <= fail_d;
        end
    end

    assign bus.ARPC_REQUEST = req_q;
    assign bus.PEER_ENABLE  = peer_en_q;
    assign bus.PEER_MAC     = peer_mac_q;
    assign bus.ARP_FAIL     = fail_q;
    assign bus.RETRY_COUNT  = retry_q;
    assign bus.STATE        = state_q;

endmodule

// File: tb/tb_aq_gemac_arp_seq.sv
// ----------------------------------------------------------------------------
// tb_aq_gemac_arp_seq
//  Directed bench for aq_gemac_arp_seq with RETRY_CYCLES=16, MAX_RETRY=3,
//  REFRESH_CYCLES=64. A timestamp-based reference model predicts every
//  output each cycle; literal checks pin the model at the key points.
// ----------------------------------------------------------------------------
module tb_aq_gemac_arp_seq;

    localparam int unsigned RC = 16;
    localparam int unsigned MR = 3;
    localparam int unsigned RF = 64;

    localparam logic [47:0] MacA = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] MacB = 48'h112233445566;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    aq_gemac_arp_seq_if bus ();

    aq_gemac_arp_seq #(
        .RETRY_CYCLES   (32'd16),
        .MAX_RETRY      (4'd3),
        .REFRESH_CYCLES (32'd64)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: mode = observable state code, timed phases measured
    // from the edge index at which they started.
    // ------------------------------------------------------------------------
    int unsigned m_cyc;
    int unsigned m_t0;
    int unsigned m_retry;
    int unsigned m_mode;
    logic [47:0] m_mac;
    bit          m_refresh;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_cyc     <= 0;
            m_t0      <= 0;
            m_retry   <= 0;
            m_mode    <= 0;
            m_mac     <= '0;
            m_refresh <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!bus.ENABLE) begin
                m_mode    <= 0;
                m_retry   <= 0;
                m_mac     <= '0;
                m_refresh <= 1'b0;
            end else if (m_mode == 0) begin
                m_mode <= 1;
            end else if ((m_mode >= 1) && (m_mode <= 3) && bus.ARPC_VALID) begin
                m_mode    <= 4;
                m_mac     <= bus.PEER_MAC_IN;
                m_retry   <= 0;
                m_t0      <= m_cyc + 1;
                m_refresh <= 1'b0;
            end else if (m_mode == 1) begin
                m_mode <= 2;
                m_t0   <= m_cyc + 1;
            end else if (m_mode == 2 || m_mode == 3) begin
                if (m_cyc - m_t0 == RC - 1) begin
                    if (m_retry + 1 == MR) begin
                        m_mode    <= 5;
                        m_refresh <= 1'b0;
                    end else begin
                        m_retry <= m_retry + 1;
                        m_mode  <= 2;
                        m_t0    <= m_cyc + 1;
                    end
                end else if (m_mode == 2 && bus.ARPC_ENABLE) begin
                    m_mode <= 3;
                end
            end else if (m_mode == 4) begin
                if (!bus.ARPC_VALID) begin
                    m_mode    <= 1;
                    m_refresh <= 1'b0;
                end else if (RF != 0 && m_cyc - m_t0 == RF - 1) begin
                    m_mode    <= 2;
                    m_t0      <= m_cyc + 1;
                    m_refresh <= 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLK) begin : compare
        logic [57:0] act;
        logic [57:0] exp;
        logic        e_pen;
        e_pen = (m_mode == 4) || (((m_mode == 2) || (m_mode == 3)) && m_refresh);
        act = {bus.STATE, bus.ARPC_REQUEST, bus.PEER_ENABLE, bus.ARP_FAIL,
               bus.RETRY_COUNT, bus.PEER_MAC};
        exp = {m_mode[2:0], (m_mode == 2), e_pen, (m_mode == 5), m_retry[3:0], m_mac};
        check("model{state,req,pen,fail,retry,mac}", {6'd0, act}, {6'd0, exp});
    end

    // Running count of cycles with ARPC_REQUEST high.
    int req_total = 0;
    always @(posedge CLK) begin
        if (bus.ARPC_REQUEST === 1'b1) req_total <= req_total + 1;
    end

    initial begin
        int req0;
        int pen_low;

        bus.ENABLE      = 1'b0;
        bus.ARPC_VALID  = 1'b0;
        bus.ARPC_ENABLE = 1'b0;
        bus.PEER_MAC_IN = 48'd0;
        #1 RST = 1'b1;
        step(2);

        // Reset state
        check("rst_state", bus.STATE, 3'd0);
        check("rst_req", bus.ARPC_REQUEST, 1'b0);
        check("rst_pen", bus.PEER_ENABLE, 1'b0);
        check("rst_mac", bus.PEER_MAC, 48'd0);
        check("rst_fail", bus.ARP_FAIL, 1'b0);
        check("rst_retry", bus.RETRY_COUNT, 4'd0);
        RST = 1'b0;
        step(1);

        // 1: cache hit
        bus.ARPC_VALID  = 1'b1;
        bus.PEER_MAC_IN = MacA;
        bus.ENABLE      = 1'b1;
        req0 = req_total;
        step(1);
        check("t1_check_state", bus.STATE, 3'd1);
        check("t1_pen_early", bus.PEER_ENABLE, 1'b0);
        step(1);
        check("t1_pen", bus.PEER_ENABLE, 1'b1);
        check("t1_mac", bus.PEER_MAC, MacA);
        check("t1_no_req", req_total - req0, 0);

        // 2: miss then resolve
        bus.ENABLE     = 1'b0;
        bus.ARPC_VALID = 1'b0;
        step(1);
        check("t2_idle_mac", bus.PEER_MAC, 48'd0);
        bus.ENABLE = 1'b1;
        req0 = req_total;
        step(4);
        check("t2_req_c3", bus.ARPC_REQUEST, 1'b1);
        bus.ARPC_ENABLE = 1'b1;
        step(1);
        check("t2_wait", bus.STATE, 3'd3);
        bus.ARPC_ENABLE = 1'b0;
        step(5);
        bus.ARPC_VALID = 1'b1;
        step(1);
        check("t2_bound", bus.STATE, 3'd4);
        check("t2_retry", bus.RETRY_COUNT, 4'd0);
        check("t2_req_len", req_total - req0, 3);

        // 3: no response, ipctrl accepts every request
        bus.ENABLE     = 1'b0;
        bus.ARPC_VALID = 1'b0;
        step(1);
        bus.ENABLE      = 1'b1;
        bus.ARPC_ENABLE = 1'b1;
        req0 = req_total;
        for (int i = 1; i <= 50; i++) begin
            step(1);
            if (i == 2)  check("t3_req0", bus.ARPC_REQUEST, 1'b1);
            if (i == 3)  check("t3_retry0", bus.RETRY_COUNT, 4'd0);
            if (i == 18) check("t3_req1", {bus.ARPC_REQUEST, bus.RETRY_COUNT}, 5'h11);
            if (i == 34) check("t3_req2", {bus.ARPC_REQUEST, bus.RETRY_COUNT}, 5'h12);
            if (i == 49) check("t3_not_yet", bus.ARP_FAIL, 1'b0);
            if (i == 50) check("t3_fail", {bus.STATE, bus.ARP_FAIL, bus.RETRY_COUNT}, 8'hB2);
        end
        check("t3_req_count", req_total - req0, 3);
        bus.ENABLE = 1'b0;
        step(1);
        check("t3_clear", {bus.STATE, bus.ARP_FAIL, bus.RETRY_COUNT}, 8'h00);

        // 4: valid arrives on the timeout cycle
        bus.ENABLE      = 1'b1;
        bus.PEER_MAC_IN = MacA;
        req0 = req_total;
        step(17);
        check("t4_pre", bus.STATE, 3'd3);
        bus.ARPC_VALID = 1'b1;
        step(1);
        check("t4_bound", {bus.STATE, bus.RETRY_COUNT, bus.ARPC_REQUEST}, {3'd4, 4'd0, 1'b0});
        check("t4_one_req", req_total - req0, 1);
        check("t4_mac", bus.PEER_MAC, MacA);

        // 5: periodic refresh
        pen_low = 0;
        for (int k = 1; k <= 65; k++) begin
            step(1);
            if (!bus.PEER_ENABLE) pen_low++;
            if (k == 60) bus.PEER_MAC_IN = MacB;
            if (k == 64) check("t5_refresh_req", {bus.STATE, bus.ARPC_REQUEST}, {3'd2, 1'b1});
            if (k == 64) check("t5_mac_held", bus.PEER_MAC, MacA);
            if (k == 65) check("t5_rebound", {bus.STATE, bus.ARPC_REQUEST}, {3'd4, 1'b0});
            if (k == 65) check("t5_mac_new", bus.PEER_MAC, MacB);
        end
        check("t5_pen_never_low", pen_low, 0);

        // 6: reset during REQ
        bus.ARPC_VALID  = 1'b0;
        bus.ARPC_ENABLE = 1'b0;
        step(1);
        check("t6_check", {bus.STATE, bus.PEER_ENABLE}, {3'd1, 1'b0});
        check("t6_mac_kept", bus.PEER_MAC, MacB);
        step(1);
        check("t6_in_req", bus.ARPC_REQUEST, 1'b1);
        #2 RST = 1'b1;
        #1;
        check("t6_async_req", bus.ARPC_REQUEST, 1'b0);
        check("t6_async_state", bus.STATE, 3'd0);
        check("t6_async_mac", bus.PEER_MAC, 48'd0);
        @(negedge CLK);
        RST             = 1'b0;
        bus.ARPC_VALID  = 1'b1;
        bus.PEER_MAC_IN = MacA;
        step(2);
        check("t6_restart", {bus.STATE, bus.PEER_ENABLE}, {3'd4, 1'b1});
        check("t6_restart_mac", bus.PEER_MAC, MacA);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
